// File: rtl/sha2_msg_loader.sv
// ---------------------------------------------------------------------------
// sha2_msg_loader
//
// Upstream feeder for a single-block SHA-256 wrapper. Collects a byte-granular
// message arriving as 32-bit beats, packs it right-aligned into a 448-bit
// buffer, tracks its length in bits, issues a one-cycle start command to the
// wrapper and follows the wrapper status through busy to done. Messages that
// would not fit one 512-bit block are rejected; a wrapper that never reports
// busy is abandoned after BUSY_TIMEOUT cycles.
//
// Ports
//   clock        in   single clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   wr_valid     in   beat valid
//   wr_ready     out  beat can be accepted (IDLE and DRAIN)
//   wr_data      in   beat bytes, first byte in [31:24]
//   wr_bytes     in   valid bytes in the beat (0..4), from the MSB end
//   wr_last      in   final beat of the message
//   sha2CSR_i    in   wrapper status: 3'b010 busy, 3'b001 done
//   plaintext    out  message, right-aligned (last byte in [7:0])
//   messageSize  out  message length in bits
//   sha2CSR      out  wrapper command, bit 2 = start
//   done         out  one-cycle pulse on hash completion
//   error        out  one-cycle pulse on rejected message or busy timeout
//   busy         out  high whenever the loader is not IDLE
// ---------------------------------------------------------------------------
module sha2_msg_loader #(
    parameter int unsigned MAX_BYTES    = 55,
    parameter int unsigned BUSY_TIMEOUT = 32
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [31:0]  wr_data,
    input  logic [2:0]   wr_bytes,
    input  logic         wr_last,
    input  logic [2:0]   sha2CSR_i,
    output logic [447:0] plaintext,
    output logic [63:0]  messageSize,
    output logic [2:0]   sha2CSR,
    output logic         done,
    output logic         error,
    output logic         busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    localparam int unsigned CNT_W = $clog2(MAX_BYTES + 1);
    localparam int unsigned TMR_W = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [CNT_W:0] MAX_CNT   = (CNT_W + 1)'(MAX_BYTES);
    localparam logic [2:0]     CSR_BUSY  = 3'b010;
    localparam logic [2:0]     CSR_DONE  = 3'b001;
    localparam logic [2:0]     CMD_START = 3'b100;

    state_t             state;
    logic [CNT_W-1:0]   byte_cnt;
    logic [TMR_W-1:0]   timer;

    logic               accept;
    logic [CNT_W:0]     sum_cnt;     // one spare bit so an overflow is visible
    logic [31:0]        beat_bits;   // beat's valid bytes, right-aligned
    logic [447:0]       shifted;
    logic [63:0]        next_size;
    logic               beat_legal;

    assign accept = wr_valid & wr_ready;

    // NOTE: every signal assigned in always_comb gets a default at the top, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sum_cnt    = {1'b0, byte_cnt} + (CNT_W + 1)'(wr_bytes);
        beat_bits  = '0;
        beat_legal = 1'b0;

        case (wr_bytes)
            3'd1:    beat_bits = {24'h0, wr_data[31:24]};
            3'd2:    beat_bits = {16'h0, wr_data[31:16]};
            3'd3:    beat_bits = {8'h0,  wr_data[31:8]};
            3'd4:    beat_bits = wr_data;
            default: beat_bits = '0;
        endcase

        shifted   = (plaintext << {wr_bytes, 3'b000}) | {416'h0, beat_bits};
        next_size = 64'(sum_cnt) << 3;

        // Only the final beat may be short. A zero-byte beat is only meaningful
        // as the sole beat of an empty message; since every earlier beat
        // carries four bytes, "first beat" is the same as byte_cnt == 0.
        if (wr_bytes > 3'd4) begin
            beat_legal = 1'b0;
        end else if (sum_cnt > MAX_CNT) begin
            beat_legal = 1'b0;
        end else if (wr_last) begin
            beat_legal = (wr_bytes != 3'd0) || (byte_cnt == '0);
        end else begin
            beat_legal = (wr_bytes == 3'd4);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register here sees the pre-edge value of every other register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the wide message buffer is reset too; it drives the
            // wrapper's data inputs directly and must not come up as garbage.
            state       <= S_IDLE;
            byte_cnt    <= '0;
            timer       <= '0;
            plaintext   <= '0;
            messageSize <= '0;
            sha2CSR     <= 3'b000;
            done        <= 1'b0;
            error       <= 1'b0;
            busy        <= 1'b0;
            wr_ready    <= 1'b1;
        end else begin
            // Pulsed outputs fall back to zero unless a branch raises them.
            done    <= 1'b0;
            error   <= 1'b0;
            sha2CSR <= 3'b000;

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (beat_legal) begin
                            plaintext   <= shifted;
                            byte_cnt    <= sum_cnt[CNT_W-1:0];
                            messageSize <= next_size;
                            if (wr_last) begin
                                state    <= S_START;
                                sha2CSR  <= CMD_START;
                                wr_ready <= 1'b0;
                                busy     <= 1'b1;
                            end
                        end else if (wr_last) begin
                            error       <= 1'b1;
                            plaintext   <= '0;
                            messageSize <= '0;
                            byte_cnt    <= '0;
                        end else begin
                            // Swallow the rest of the bad message before
                            // reporting it, so its tail is not taken as a
                            // new message.
                            state <= S_DRAIN;
                            busy  <= 1'b1;
                        end
                    end
                end

                S_DRAIN: begin
                    if (accept && wr_last) begin
                        state       <= S_IDLE;
                        error       <= 1'b1;
                        busy        <= 1'b0;
                        plaintext   <= '0;
                        messageSize <= '0;
                        byte_cnt    <= '0;
                    end
                end

                S_START: begin
                    state <= S_WAIT_BUSY;
                    timer <= TMR_W'(BUSY_TIMEOUT - 1);
                end

                S_WAIT_BUSY: begin
                    // A leftover done status from the previous hash is not
                    // busy, so it simply lets the timer run.
                    if (sha2CSR_i == CSR_BUSY) begin
                        state <= S_WAIT_DONE;
                    end else if (timer == '0) begin
                        state       <= S_IDLE;
                        error       <= 1'b1;
                        busy        <= 1'b0;
                        wr_ready    <= 1'b1;
                        plaintext   <= '0;
                        messageSize <= '0;
                        byte_cnt    <= '0;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end

                S_WAIT_DONE: begin
                    if (sha2CSR_i == CSR_DONE) begin
                        state       <= S_IDLE;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        wr_ready    <= 1'b1;
                        plaintext   <= '0;
                        messageSize <= '0;
                        byte_cnt    <= '0;
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                    wr_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
